load_cdb_arbiter: RTL

Round-robin arbiter that decides which load buffer entries drive the CDB each cycle. It sits between the load buffer and the issue/CDB stage. It takes the per-entry completion requests and the number of CDB slots the issue stage has left for loads this cycle, and returns same-cycle grants. It also keeps a rotating priority pointer and a starvation monitor, so the issue stage can reserve a CDB slot for loads when they have been shut out too long.

---
 rtl/load_cdb_arbiter_pkg.sv | 15 +
 rtl/load_cdb_arbiter_psel.sv | 31 +++
 rtl/load_cdb_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/load_cdb_arbiter_pkg.sv
// Shared sizing for the load CDB arbiter.
// Load buffer depth, CDB ports for loads, starvation threshold.
package load_cdb_arbiter_pkg;

  localparam int LOAD_BUFFER_SZ    = 8;
  localparam int LOAD_CDB_MAX_GNT  = 2;
  localparam int LOAD_STARVE_LIMIT = 4;

  function automatic int unsigned clog2_1(
    input int unsigned v
  );
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/load_cdb_arbiter_psel.sv
// Priority selector: grants the lowest-index set bits,
// up to limit_i of them, and reports count and last index.
module psel_gen #(
  parameter int WIDTH = 8,
  parameter int REQS  = 2,
  localparam int CW   = $clog2(REQS + 1),
  localparam int LW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [CW-1:0]    limit_i,
  output logic [WIDTH-1:0] gnt_o,
  output logic [CW-1:0]    cnt_o,
  output logic [LW-1:0]    last_o,
  output logic             any_o
);

  always_comb begin
    gnt_o  = '0;
    cnt_o  = '0;
    last_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req_i[i] && (cnt_o < limit_i)) begin
        gnt_o[i] = 1'b1;
        cnt_o    = cnt_o + CW'(1);
        last_o   = LW'(i);
      end
    end
    any_o = |gnt_o;
  end

endmodule

// File: rtl/load_cdb_arbiter.sv
// Round-robin load CDB arbiter with same-cycle grants,
// rotating priority pointer and starvation monitor.
module load_cdb_arbiter
  import load_cdb_arbiter_pkg::*;
#(
  parameter int N            = LOAD_BUFFER_SZ,
  parameter int MAX_GNT      = LOAD_CDB_MAX_GNT,
  parameter int STARVE_LIMIT = LOAD_STARVE_LIMIT,
  localparam int CW          = $clog2(MAX_GNT + 1),
  localparam int PW          = $clog2(N),
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  load_cdb_req,
  input  logic [CW-1:0] load_slots_avail,
  output logic [N-1:0]  load_cdb_gnt,
  output logic [CW-1:0] load_gnt_count,
  output logic          load_starve,
  output logic [PW-1:0] rr_ptr
);

  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]  starve_cnt_q, starve_cnt_d;
  logic           load_starve_q, load_starve_d;

  logic [CW-1:0]  slots;
  logic [N-1:0]   rot_req;
  logic [N-1:0]   rot_gnt;
  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [CW-1:0]  sel_cnt;
  logic [PW-1:0]  sel_last;
  logic           sel_any;

  assign slots = (load_slots_avail > CW'(MAX_GNT))
               ? CW'(MAX_GNT) : load_slots_avail;

  // Rotate so entry rr_ptr sits at bit 0, then rotate grants back.
  assign req_dbl = {load_cdb_req, load_cdb_req} >> rr_ptr_q;
  assign rot_req = req_dbl[N-1:0];

  psel_gen #(
    .WIDTH (N),
    .REQS  (MAX_GNT)
  ) u_psel (
    .req_i   (rot_req),
    .limit_i (slots),
    .gnt_o   (rot_gnt),
    .cnt_o   (sel_cnt),
    .last_o  (sel_last),
    .any_o   (sel_any)
  );

  assign gnt_dbl = {rot_gnt, rot_gnt} << rr_ptr_q;

  always_comb begin
    load_cdb_gnt   = gnt_dbl[2*N-1:N];
    load_gnt_count = sel_cnt;
    if (reset) begin
      load_cdb_gnt   = '0;
      load_gnt_count = '0;
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    starve_cnt_d  = starve_cnt_q;
    if (sel_any) begin
      rr_ptr_d = rr_ptr_q + sel_last + PW'(1);
    end
    if (sel_any || (load_cdb_req == '0)) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
    load_starve_d = (starve_cnt_d == SW'(STARVE_LIMIT));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      starve_cnt_q  <= '0;
      load_starve_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      starve_cnt_q  <= starve_cnt_d;
      load_starve_q <= load_starve_d;
    end
  end

  assign rr_ptr      = rr_ptr_q;
  assign load_starve = load_starve_q;

endmodule
